// File: rtl/move_input_if.sv
// move_input_if -- character stream handshake for the tic-tac-toe move parser.
//   ch_data  : ASCII character offered by the player-side source
//   ch_valid : ch_data holds a character this cycle
//   ch_ready : sink can take a character; transfer when ch_valid && ch_ready
// master = character source (terminal/UART side), slave = move_input.
interface move_input_if;
  logic [7:0] ch_data;
  logic       ch_valid;
  logic       ch_ready;

  modport master (output ch_data, output ch_valid, input ch_ready);
  modport slave  (input ch_data, input ch_valid, output ch_ready);
endinterface

// File: rtl/move_input.sv
// move_input -- player-input front end for tic-tac-toe.
// Parses '1'..'9' cell selections confirmed by newline, validates each move
// against the board, writes the mover's mark and toggles the turn. Owns the
// board/turn registers consumed by the display path and the win checker.
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   ch          : character stream (slave side of move_input_if)
//   game_over   : from win/draw checker, locks moves while high
//   board       : 9 cells x 2 bits, cell i = board[2i+1:2i] (00 blank, 01 X, 10 O)
//   turn        : 0 = X to move, 1 = O to move
//   move_count  : accepted moves since last clear (0..9)
//   move_done   : pulse when an accepted move becomes visible
//   new_game    : pulse after a clear completes
//   err         : pulse on a rejected character or move
//   err_code    : cause of last error (1 bad char, 2 occupied, 3 game over)
module move_input #(
  parameter bit ACCEPT_CR = 1'b1,
  parameter bit X_FIRST   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  move_input_if.slave       ch,
  input  logic              game_over,
  output logic [17:0]       board,
  output logic              turn,
  output logic [3:0]        move_count,
  output logic              move_done,
  output logic              new_game,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [1:0] WAIT_CELL = 2'd0;
  localparam logic [1:0] ARMED     = 2'd1;
  localparam logic [1:0] CHECK     = 2'd2;
  localparam logic [1:0] CLEAR     = 2'd3;

  localparam logic [1:0] CELL_BLANK = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic TURN_INIT = !X_FIRST;

  logic [1:0]  state_reg;
  logic [3:0]  idx_reg;
  logic [15:0] occupied;
  logic        xfer;
  logic        is_digit;
  logic        is_reset_ch;
  logic        is_space;
  logic        is_lf;
  logic        is_cr;
  logic [7:0]  digit_off;
  logic [1:0]  mark;

  // Ready is forced low during reset so nothing is consumed before the
  // registers have settled.
  assign ch.ch_ready = !rst && ((state_reg == WAIT_CELL) || (state_reg == ARMED));
  assign xfer        = ch.ch_valid && ch.ch_ready;

  assign is_digit    = (ch.ch_data >= 8'h31) && (ch.ch_data <= 8'h39);
  assign is_reset_ch = (ch.ch_data == 8'h72) || (ch.ch_data == 8'h52);
  assign is_space    = (ch.ch_data == 8'h20);
  assign is_lf       = (ch.ch_data == 8'h0A);
  assign is_cr       = (ch.ch_data == 8'h0D);
  assign digit_off   = ch.ch_data - 8'h31;
  assign mark        = turn ? CELL_O : CELL_X;

  // Per-cell occupancy, padded to 16 entries so the 4-bit index addresses
  // it without width mismatch; indices 9..15 cannot be latched anyway.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_occ
      assign occupied[gi] = (board[2*gi +: 2] != CELL_BLANK);
    end
  endgenerate
  assign occupied[15:9] = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= WAIT_CELL;
      idx_reg    <= '0;
      board      <= '0;
      turn       <= TURN_INIT;
      move_count <= '0;
      move_done  <= 1'b0;
      new_game   <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      move_done <= 1'b0;
      new_game  <= 1'b0;
      err       <= 1'b0;
      case (state_reg)
        WAIT_CELL: begin
          if (xfer) begin
            if (is_digit) begin
              idx_reg   <= digit_off[3:0];
              state_reg <= ARMED;
            end else if (is_reset_ch) begin
              state_reg <= CLEAR;
            end else if (!(is_space || is_lf || is_cr)) begin
              err      <= 1'b1;
              err_code <= 2'd1;
            end
          end
        end
        ARMED: begin
          if (xfer) begin
            if (is_digit) begin
              idx_reg <= digit_off[3:0];  // last digit wins
            end else if (is_lf || (ACCEPT_CR && is_cr)) begin
              state_reg <= CHECK;
            end else if (is_reset_ch) begin
              state_reg <= CLEAR;
            end else if (!is_space) begin
              err       <= 1'b1;
              err_code  <= 2'd1;
              state_reg <= WAIT_CELL;
            end
          end
        end
        CHECK: begin
          if (game_over) begin
            err      <= 1'b1;
            err_code <= 2'd3;
          end else if (occupied[idx_reg]) begin
            err      <= 1'b1;
            err_code <= 2'd2;
          end else begin
            for (int i = 0; i < 9; i++) begin
              if (idx_reg == 4'(i)) board[2*i +: 2] <= mark;
            end
            turn      <= !turn;
            if (move_count != 4'd9) move_count <= move_count + 4'd1;
            move_done <= 1'b1;
          end
          state_reg <= WAIT_CELL;
        end
        CLEAR: begin
          board      <= '0;
          turn       <= TURN_INIT;
          move_count <= '0;
          err_code   <= 2'd0;
          new_game   <= 1'b1;
          state_reg  <= WAIT_CELL;
        end
        default: state_reg <= WAIT_CELL;
      endcase
    end
  end

endmodule
